// File: rtl/demux_one_to_four_reg.sv
// Registered 1-to-4 demultiplexer that rebuilds a 4-lane frame from serial words.
// Optional frame parity output is enabled by defining DEMUX_FRAME_PARITY_EN.
module demux_one_to_four_reg #(
  parameter int WIDTH = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [WIDTH-1:0]   i_din,
  input  logic               i_din_valid,
  input  logic [1:0]         i_sel,
  input  logic               i_auto,
  input  logic               i_clr,
  output logic [4*WIDTH-1:0] o_dout,
  output logic [3:0]         o_dout_valid,
  output logic               o_frame_done,
`ifdef DEMUX_FRAME_PARITY_EN
  output logic               o_frame_parity,
`endif
  output logic [1:0]         o_ptr
);

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_state_t;

  lane_state_t        r_state;
  logic [4*WIDTH-1:0] r_dout;
  logic [3:0]         r_dout_valid;
  logic               r_frame_done;

  logic [1:0]         w_lane;
  logic               w_auto_wrap;

  assign w_lane      = i_auto ? r_state : i_sel;
  assign w_auto_wrap = i_auto && (r_state == LANE3);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_state      <= LANE0;
      r_dout       <= '0;
      r_dout_valid <= 4'b0000;
      r_frame_done <= 1'b0;
    end else if (i_din_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane == i[1:0]) begin
          r_dout[i*WIDTH +: WIDTH] <= i_din;
        end
      end
      r_dout_valid <= 4'b0001 << w_lane;
      r_frame_done <= w_auto_wrap;
      // The pointer only walks in auto mode, so a manual detour resumes where it left off
      if (i_auto) begin
        case (r_state)
          LANE0:   r_state <= LANE1;
          LANE1:   r_state <= LANE2;
          LANE2:   r_state <= LANE3;
          default: r_state <= LANE0;
        endcase
      end
    end else begin
      r_dout_valid <= 4'b0000;
      r_frame_done <= 1'b0;
    end
  end

`ifdef DEMUX_FRAME_PARITY_EN
  logic r_frame_parity;
  logic w_frame_parity;

  // Lane 3 is still being written, so fold the incoming word in place of its old value
  assign w_frame_parity = ^{i_din, r_dout[3*WIDTH-1:0]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_frame_parity <= 1'b0;
    end else if (i_din_valid && w_auto_wrap) begin
      r_frame_parity <= w_frame_parity;
    end
  end

  assign o_frame_parity = r_frame_parity;
`endif

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_frame_done = r_frame_done;
  assign o_ptr        = r_state;

endmodule
